adc_sample_framer: RTL

- Upstream front end of the FourierTransform datapath. It sits between the differential ADC pins (sample_p/n, enable_p/n) and the bank of Herzel (Goertzel) filters.
- Registers the pin pair, checks differential integrity and converts offset-binary samples to two's complement.
- Gates exactly NS samples per armed frame into a valid/first/last stream that all Herzel instances consume in lockstep.
- Reports frame completion and errors as status bits for the SPI STATUS register.

---
 rtl/ft_pkg.sv | 42 ++++
 rtl/adc_sample_framer_if.sv | 23 ++
 rtl/adc_sample_framer_diff_rx.sv | 41 ++++
 rtl/adc_sample_framer.sv | 176 +++++++++++++++++
 4 files changed

// File: rtl/ft_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : ft_pkg
//  Description : Shared types and constants for the FourierTransform datapath:
//                framer FSM state encoding, SPI STATUS register bit map and
//                the offset-binary to two's complement helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package ft_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        RUN   = 2'd2,
        DONE  = 2'd3
    } state_t;

    // SPI STATUS register bit positions
    localparam int STATUS_FRAME_DONE = 0;
    localparam int STATUS_ERR_DIFF   = 1;
    localparam int STATUS_ERR_SHORT  = 2;
    localparam int STATUS_BUSY       = 3;

    localparam logic [15:0] STATUS_CORDIC_MSK     = 16'h0010;
    localparam logic [15:0] STATUS_HERZEL_ALL_MSK = 16'hFF00;

    // Widest sample the conversion helper accepts
    localparam int OB2TC_MAXW = 32;

    // Offset binary -> two's complement is an MSB flip at bit (w-1).
    // Callers zero-extend into OB2TC_MAXW bits and truncate the result.
    function automatic logic [OB2TC_MAXW-1:0] ob2tc(
        input logic [OB2TC_MAXW-1:0] x,
        input int unsigned           w
    );
        logic [OB2TC_MAXW-1:0] m;
        m = OB2TC_MAXW'(1) << (w - 1);
        return x ^ m;
    endfunction

endpackage : ft_pkg
`default_nettype wire

// File: rtl/adc_sample_framer_if.sv
`default_nettype none
// ============================================================================
//  Interface   : adc_sample_framer_if
//  Description : Sample stream from the framer to the Herzel filter bank.
//                No backpressure: the consumer takes one sample per clock.
//  Signals     : data  - DW  signed sample (two's complement)
//                valid - 1   data valid this cycle
//                first - 1   first sample of a frame (qualified by valid)
//                last  - 1   sample NS-1 of a frame (qualified by valid)
//  Revision    : 1.0 - initial release
// ============================================================================
interface adc_sample_framer_if #(
    parameter int DW = 8
);
    logic [DW-1:0] data;
    logic          valid;
    logic          first;
    logic          last;

    modport master (output data, output valid, output first, output last);
    modport slave  (input  data, input  valid, input  first, input  last);
endinterface : adc_sample_framer_if
`default_nettype wire

// File: rtl/adc_sample_framer_diff_rx.sv
`default_nettype none
// ============================================================================
//  Module      : diff_rx
//  Description : Stage-0 register for a bundle of differential pin pairs.
//                Registers the positive legs and a per-bit flag that is set
//                when the two legs of a pair are equal (not complementary).
//  Ports       : clk    - system clock
//                rstn   - asynchronous active-low reset
//                p_i    - W  positive legs
//                n_i    - W  negative legs
//                data_o - W  registered positive legs
//                mism_o - W  registered per-bit leg mismatch
//  Revision    : 1.0 - initial release
// ============================================================================
module diff_rx #(
    parameter int W = 9
) (
    input  wire logic         clk,
    input  wire logic         rstn,
    input  wire logic [W-1:0] p_i,
    input  wire logic [W-1:0] n_i,
    output logic      [W-1:0] data_o,
    output logic      [W-1:0] mism_o
);
    logic [W-1:0] data_q;
    logic [W-1:0] mism_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_q <= '0;
            mism_q <= '0;
        end else begin
            data_q <= p_i;
            mism_q <= ~(p_i ^ n_i);
        end
    end

    assign data_o = data_q;
    assign mism_o = mism_q;
endmodule : diff_rx
`default_nettype wire

// File: rtl/adc_sample_framer.sv
`default_nettype none
// ============================================================================
//  Module      : adc_sample_framer
//  Description : Front end of the FourierTransform datapath. Registers the
//                differential ADC pins, checks leg integrity, converts
//                offset-binary samples to two's complement and gates exactly
//                NS samples per armed frame onto the Herzel sample stream.
//  Ports       : clk, rstn          - clock, async active-low reset
//                sample_p/sample_n  - DW differential ADC sample
//                enable_p/enable_n  - differential ADC data-valid
//                arm, abort         - one-cycle control pulses
//                smp                - sample stream (master modport)
//                frame_done         - pulse the cycle after the last sample
//                busy               - frame armed or running
//                smp_cnt            - samples issued in current/last frame
//                err_diff, err_short- sticky error flags
//  Revision    : 1.0 - initial release
// ============================================================================
module adc_sample_framer
    import ft_pkg::*;
#(
    parameter int NS = 100000,
    parameter int DW = 8
) (
    input  wire logic                     clk,
    input  wire logic                     rstn,
    input  wire logic [DW-1:0]            sample_p,
    input  wire logic [DW-1:0]            sample_n,
    input  wire logic                     enable_p,
    input  wire logic                     enable_n,
    input  wire logic                     arm,
    input  wire logic                     abort,
    adc_sample_framer_if.master           smp,
    output logic                          frame_done,
    output logic                          busy,
    output logic [$clog2(NS+1)-1:0]       smp_cnt,
    output logic                          err_diff,
    output logic                          err_short
);
    localparam int CW = $clog2(NS+1);

    // ---------------- stage 0 ----------------
    logic [DW:0] rx_data_w;
    logic [DW:0] rx_mism_w;

    diff_rx #(.W(DW+1)) u_diff_rx (
        .clk    (clk),
        .rstn   (rstn),
        .p_i    ({enable_p, sample_p}),
        .n_i    ({enable_n, sample_n}),
        .data_o (rx_data_w),
        .mism_o (rx_mism_w)
    );

    // enable counts only when the legs are complementary with _p high
    logic          en_w;
    logic          diff_w;
    logic [DW-1:0] smp_w;
    logic [DW-1:0] conv_w;

    assign en_w   = rx_data_w[DW] & ~rx_mism_w[DW];
    assign diff_w = |rx_mism_w;
    assign smp_w  = rx_data_w[DW-1:0];
    assign conv_w = DW'(ob2tc(OB2TC_MAXW'(smp_w), DW));

    // ---------------- FSM + output register ----------------
    state_t        state_q, state_d;
    logic          en_dly_q;
    logic          valid_q, valid_d;
    logic          first_q, first_d;
    logic          last_q,  last_d;
    logic          done_q,  done_d;
    logic [CW-1:0] cnt_q,   cnt_d;
    logic          ediff_q, ediff_d;
    logic          eshort_q, eshort_d;
    logic [DW-1:0] data_q;
    logic          issue_w;

    always_comb begin
        state_d  = state_q;
        valid_d  = 1'b0;
        first_d  = 1'b0;
        last_d   = 1'b0;
        done_d   = 1'b0;
        cnt_d    = cnt_q;
        ediff_d  = ediff_q;
        eshort_d = eshort_q;
        issue_w  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (arm && !abort) begin
                    state_d  = ARMED;
                    cnt_d    = '0;
                    ediff_d  = 1'b0;
                    eshort_d = 1'b0;
                end
            end
            ARMED: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (en_w && !en_dly_q) begin
                    // the sample riding on the rising edge is sample 0
                    state_d = RUN;
                    issue_w = 1'b1;
                end
            end
            RUN: begin
                if (abort) begin
                    state_d = IDLE;
                end else if (en_w) begin
                    issue_w = 1'b1;
                    if (cnt_q == CW'(NS-1)) begin
                        state_d = DONE;
                    end
                end else begin
                    eshort_d = 1'b1;
                    state_d  = IDLE;
                end
            end
            DONE: begin
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (issue_w) begin
            valid_d = 1'b1;
            first_d = (cnt_q == '0);
            last_d  = (cnt_q == CW'(NS-1));
            cnt_d   = cnt_q + CW'(1);
            // _p leg is authoritative, so the sample still goes out
            if (diff_w) begin
                ediff_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q  <= IDLE;
            en_dly_q <= 1'b0;
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            done_q   <= 1'b0;
            cnt_q    <= '0;
            ediff_q  <= 1'b0;
            eshort_q <= 1'b0;
            data_q   <= '0;
        end else begin
            state_q  <= state_d;
            en_dly_q <= en_w;
            valid_q  <= valid_d;
            first_q  <= first_d;
            last_q   <= last_d;
            done_q   <= done_d;
            cnt_q    <= cnt_d;
            ediff_q  <= ediff_d;
            eshort_q <= eshort_d;
            data_q   <= conv_w;
        end
    end

    assign smp.data   = data_q;
    assign smp.valid  = valid_q;
    assign smp.first  = first_q;
    assign smp.last   = last_q;
    assign frame_done = done_q;
    assign busy       = (state_q == ARMED) || (state_q == RUN);
    assign smp_cnt    = cnt_q;
    assign err_diff   = ediff_q;
    assign err_short  = eshort_q;
endmodule : adc_sample_framer
`default_nettype wire
